// File: rtl/bcd_scan_decoder_pkg.sv
// Shared types and helpers for the multiplexed BCD-to-decimal display driver.
package bcd_pkg;

  localparam int DEC_W = 10;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_e;

  function automatic logic bcd_valid(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_scan_decoder_if.sv
// Load handshake and display drive bundle between the BCD source, the scanner and the display board.
interface bcd_scan_decoder_if #(
  parameter int NDIG = 4
);
  import bcd_pkg::*;

  logic                  load_valid;
  logic                  load_ready;
  logic [4*NDIG-1:0]     bcd_in;
  logic [DEC_W-1:0]      dec_out;
  logic [NDIG-1:0]       dig_sel;
  logic [NDIG-1:0]       code_err;

  modport master (
    output load_valid, bcd_in,
    input  load_ready, dec_out, dig_sel, code_err
  );

  modport slave (
    input  load_valid, bcd_in,
    output load_ready, dec_out, dig_sel, code_err
  );

endinterface

// File: rtl/bcd_scan_decoder_onehot.sv
// Combinational BCD digit to 10-line one-hot numeral decoder; codes 10..15 give all lines dark.
module bcd_to_dec_onehot
  import bcd_pkg::*;
(
  input  logic [3:0]       i_bcd,
  output logic [DEC_W-1:0] o_dec
);

  generate
    for (genvar gi = 0; gi < DEC_W; gi++) begin : g_line
      assign o_dec[gi] = (i_bcd == 4'(gi));
    end
  endgenerate

endmodule

// File: rtl/bcd_scan_decoder.sv
// Time-multiplexed BCD display scanner with pending/active double buffering (tear-free frame updates).
// Optional leading-zero blanking is enabled by defining BCD_SCAN_LZB_EN.
module bcd_scan_decoder
  import bcd_pkg::*;
#(
  parameter int NDIG         = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  bcd_scan_decoder_if.slave bus
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NDIG - 1);

  state_e                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [4*NDIG-1:0]     r_pend;
  logic                  r_pend_full;
  logic [4*NDIG-1:0]     r_active;
  logic [DEC_W-1:0]      r_dec;
  logic [NDIG-1:0]       r_sel;
  logic [NDIG-1:0]       r_err;

  state_e                w_state_nx;
  logic [CNT_W-1:0]      w_cnt_nx;
  logic [IDX_W-1:0]      w_idx_nx;
  logic                  w_frame_start;
  logic                  w_swap;
  logic                  w_accept;
  logic [4*NDIG-1:0]     w_active_nx;
  logic [3:0]            w_digit [NDIG];
  logic [NDIG-1:0]       w_err_nx;
  logic [NDIG-1:0]       w_sel_nx;
  logic [3:0]            w_dig_nx;
  logic [DEC_W-1:0]      w_onehot;
  logic                  w_dark;

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt + 1'b1;
    w_idx_nx   = r_idx;
    case (r_state)
      ST_BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_state_nx = ST_ON;
          w_cnt_nx   = '0;
        end
      end
      default: begin
        if (r_cnt == SCAN_LAST) begin
          w_state_nx = ST_BLANK;
          w_cnt_nx   = '0;
          w_idx_nx   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end
      end
    endcase
  end

  // First cycle of a frame: the swap lands before digit 0 is lit, even with a single blank cycle.
  assign w_frame_start = (r_state == ST_BLANK) && (r_idx == '0) && (r_cnt == '0);
  assign w_swap        = w_frame_start && r_pend_full;
  assign w_accept      = bus.load_valid && !r_pend_full;
  assign w_active_nx   = w_swap ? r_pend : r_active;

  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
      assign w_digit[gi]  = w_active_nx[4*gi +: 4];
      assign w_err_nx[gi] = ~bcd_valid(w_digit[gi]);
      assign w_sel_nx[gi] = (w_idx_nx == IDX_W'(gi));
    end
  endgenerate

  assign w_dig_nx = w_digit[w_idx_nx];

  bcd_to_dec_onehot u_onehot (
    .i_bcd (w_dig_nx),
    .o_dec (w_onehot)
  );

`ifdef BCD_SCAN_LZB_EN
  logic [NDIG-1:0] w_zero;
  logic [NDIG-1:0] w_lz;

  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_zero
      assign w_zero[gi] = (w_digit[gi] == 4'd0);
    end
  endgenerate

  // w_lz[i]: digit i and every more significant digit are zero.
  always_comb begin
    w_lz           = '0;
    w_lz[NDIG-1]   = w_zero[NDIG-1];
    for (int i = NDIG - 2; i >= 0; i--) begin
      w_lz[i] = w_zero[i] && w_lz[i+1];
    end
  end

  assign w_dark = w_lz[w_idx_nx] && (w_idx_nx != '0);
`else
  assign w_dark = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_BLANK;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_pend      <= '0;
      r_pend_full <= 1'b0;
      r_active    <= '0;
      r_dec       <= '0;
      r_sel       <= '0;
      r_err       <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_idx    <= w_idx_nx;
      r_active <= w_active_nx;
      r_err    <= w_err_nx;

      if (w_swap) begin
        r_pend_full <= 1'b0;
      end else if (w_accept) begin
        r_pend      <= bus.bcd_in;
        r_pend_full <= 1'b1;
      end

      if (w_state_nx == ST_ON) begin
        r_sel <= w_sel_nx;
        r_dec <= w_dark ? '0 : w_onehot;
      end else begin
        r_sel <= '0;
        r_dec <= '0;
      end
    end
  end

  assign bus.load_ready = ~r_pend_full;
  assign bus.dec_out    = r_dec;
  assign bus.dig_sel    = r_sel;
  assign bus.code_err   = r_err;

endmodule

// File: tb/tb_bcd_scan_decoder.sv
// Self-checking bench for bcd_scan_decoder (NDIG=4, SCAN_DIV=4, BLANK_CYCLES=2, 24-cycle frame).
// Builds with or without BCD_SCAN_LZB_EN; the expected table follows the macro.
module tb_bcd_scan_decoder;

  localparam int NDIG  = 4;
  localparam int SCAN  = 4;
  localparam int BLANK = 2;
  localparam int SLOT  = SCAN + BLANK;
  localparam int FRAME = NDIG * SLOT;

  typedef struct {
    logic [15:0] bcd;
    logic [39:0] dec;
    logic [3:0]  err;
    int          delay;
  } vec_t;

  typedef struct {
    logic [39:0] dec;
    logic [3:0]  err;
    int          rise;
  } sb_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  vec_t tbl [7];
  vec_t zero_vec;
  sb_t  cur;
  sb_t  sb_q [$];

  bcd_scan_decoder_if #(.NDIG(NDIG)) bus ();

  bcd_scan_decoder #(
    .NDIG         (NDIG),
    .SCAN_DIV     (SCAN),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] oh(input int k);
    logic [9:0] v;
    v = '0;
    if (k >= 0) v[k] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    cyc++;
  endtask

  // Expected drive for the current cycle from its position in the frame.
  task automatic check_cycle(input logic [39:0] dec, input logic [3:0] err);
    int ph, d, p;
    ph = cyc % FRAME;
    d  = ph / SLOT;
    p  = ph % SLOT;
    if (p < BLANK) begin
      chk("sel_blank", 32'(bus.dig_sel), 32'd0);
      chk("dec_blank", 32'(bus.dec_out), 32'd0);
    end else begin
      chk("sel_on", 32'(bus.dig_sel), 32'(1) << d);
      chk("dec_on", 32'(bus.dec_out), 32'(dec[d*10 +: 10]));
    end
    chk("code_err", 32'(bus.code_err), 32'(err));
  endtask

  task automatic check_frame_rest();
    for (int k = 0; k < FRAME; k++) begin
      check_cycle(cur.dec, cur.err);
      if (cyc % FRAME == FRAME - 1) break;
      next_cycle();
    end
  endtask

  task automatic do_load(input vec_t v);
    sb_t e;
    for (int k = 0; k < 2 * FRAME; k++) begin
      if (bus.load_ready) break;
      next_cycle();
    end
    chk("ready_before_load", 32'(bus.load_ready), 32'd1);
    bus.load_valid = 1'b1;
    bus.bcd_in     = v.bcd;
    e.dec  = v.dec;
    e.err  = v.err;
    e.rise = (cyc / FRAME + 1) * FRAME + 1;
    sb_q.push_back(e);
    $display("load bcd=%h at cyc=%0d, expect swap visible at cyc=%0d", v.bcd, cyc, e.rise);
    next_cycle();
    bus.load_valid = 1'b0;
    bus.bcd_in     = 16'($urandom);
    chk("ready_drop", 32'(bus.load_ready), 32'd0);
    check_cycle(cur.dec, cur.err);
  endtask

  // Old frame keeps showing until load_ready rises, then the popped frame must appear.
  task automatic pop_and_check();
    sb_t e;
    bit  seen;
    seen = 1'b0;
    e = sb_q.pop_front();
    for (int k = 0; k < 3 * FRAME; k++) begin
      next_cycle();
      if (bus.load_ready) begin
        seen = 1'b1;
        break;
      end
      check_cycle(cur.dec, cur.err);
    end
    chk("ready_rise_cyc", seen ? 32'(cyc) : 32'hFFFF_FFFF, 32'(e.rise));
    cur = e;
    check_frame_rest();
    $display("frame dec=%h err=%h checked ending cyc=%0d", e.dec, e.err, cyc);
  endtask

  initial begin
    logic [9:0] z;
    z = 10'h000;
    checks = 0;
    errors = 0;
    cyc    = 0;

`ifdef BCD_SCAN_LZB_EN
    zero_vec = '{16'h0000, {z, z, z, oh(0)}, 4'h0, 0};
    tbl[1]   = '{16'h0A3F, {z, z, oh(3), z}, 4'b0101, 0};
    tbl[2]   = '{16'h0050, {z, z, oh(5), oh(0)}, 4'h0, 3};
    tbl[3]   = '{16'h0900, {z, oh(9), oh(0), oh(0)}, 4'h0, 10};
`else
    zero_vec = '{16'h0000, {oh(0), oh(0), oh(0), oh(0)}, 4'h0, 0};
    tbl[1]   = '{16'h0A3F, {oh(0), z, oh(3), z}, 4'b0101, 0};
    tbl[2]   = '{16'h0050, {oh(0), oh(0), oh(5), oh(0)}, 4'h0, 3};
    tbl[3]   = '{16'h0900, {oh(0), oh(9), oh(0), oh(0)}, 4'h0, 10};
`endif
    tbl[0] = '{16'h1947, {oh(1), oh(9), oh(4), oh(7)}, 4'h0, 0};
    tbl[4] = '{16'hFFFF, {z, z, z, z}, 4'hF, 17};
    tbl[5] = '{16'h8765, {oh(8), oh(7), oh(6), oh(5)}, 4'h0, 0};
    tbl[6] = '{16'h4321, {oh(4), oh(3), oh(2), oh(1)}, 4'h0, 5};

    cur.dec  = zero_vec.dec;
    cur.err  = zero_vec.err;
    cur.rise = 0;

    bus.load_valid = 1'b0;
    bus.bcd_in     = '0;
    rst_n          = 1'b0;
    #3;
    chk("rst_dec", 32'(bus.dec_out), 32'd0);
    chk("rst_sel", 32'(bus.dig_sel), 32'd0);
    chk("rst_err", 32'(bus.code_err), 32'd0);
    chk("rst_ready", 32'(bus.load_ready), 32'd1);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;

    // Frame 0 shows zeros; load 1947 at cycle 5, a second load at cycle 10 must be ignored.
    for (int k = 0; k < 5; k++) begin
      check_cycle(cur.dec, cur.err);
      chk("ready_idle", 32'(bus.load_ready), 32'd1);
      next_cycle();
    end
    do_load(tbl[0]);
    while (cyc < 10) begin
      next_cycle();
      check_cycle(cur.dec, cur.err);
    end
    bus.load_valid = 1'b1;
    bus.bcd_in     = 16'h2222;
    $display("ignored load attempt bcd=2222 at cyc=%0d", cyc);
    chk("ready_full", 32'(bus.load_ready), 32'd0);
    next_cycle();
    bus.load_valid = 1'b0;
    check_cycle(cur.dec, cur.err);
    pop_and_check();

    // Load exactly on the boundary cycle: old digits persist a whole extra frame.
    next_cycle();
    do_load(tbl[1]);
    pop_and_check();

    for (int i = 2; i < 6; i++) begin
      next_cycle();
      check_cycle(cur.dec, cur.err);
      for (int d = 0; d < tbl[i].delay; d++) begin
        next_cycle();
        check_cycle(cur.dec, cur.err);
      end
      do_load(tbl[i]);
      pop_and_check();
    end

    // Asynchronous reset mid-ON with pending full.
    next_cycle();
    check_cycle(cur.dec, cur.err);
    for (int d = 0; d < tbl[6].delay; d++) begin
      next_cycle();
      check_cycle(cur.dec, cur.err);
    end
    do_load(tbl[6]);
    for (int k = 0; k < FRAME; k++) begin
      if (cyc % FRAME == 10) break;
      next_cycle();
      check_cycle(cur.dec, cur.err);
    end
    chk("pend_full_before_rst", 32'(bus.load_ready), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    $display("async reset asserted at cyc=%0d", cyc);
    chk("async_rst_dec", 32'(bus.dec_out), 32'd0);
    chk("async_rst_sel", 32'(bus.dig_sel), 32'd0);
    chk("async_rst_err", 32'(bus.code_err), 32'd0);
    chk("async_rst_ready", 32'(bus.load_ready), 32'd1);
    sb_q.delete();
    cur.dec = zero_vec.dec;
    cur.err = zero_vec.err;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      check_cycle(cur.dec, cur.err);
      chk("ready_after_rst", 32'(bus.load_ready), 32'd1);
      if (k < 2 * FRAME - 1) next_cycle();
    end
    $display("post-reset frames checked ending cyc=%0d", cyc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
